// File: rtl/note_player_pkg.sv
// Shared definitions for the note player: FSM state encoding and the note
// pitch/duration constants used by upstream sequencers.
package note_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Half-periods in cycles of a 25 MHz clock, fourth octave (C4..B4).
    localparam logic [15:0] DO_4  = 16'd47778;
    localparam logic [15:0] RE_4  = 16'd42566;
    localparam logic [15:0] MI_4  = 16'd37921;
    localparam logic [15:0] FA_4  = 16'd35793;
    localparam logic [15:0] SOL_4 = 16'd31888;
    localparam logic [15:0] LA_4  = 16'd28409;
    localparam logic [15:0] SI_4  = 16'd25310;

    // Note lengths at 120 bpm, 25 MHz clock.
    localparam logic [23:0] DUR_SIXTEENTH = 24'd3_125_000;
    localparam logic [23:0] DUR_EIGHTH    = 24'd6_250_000;
    localparam logic [23:0] DUR_QUARTER   = 24'd12_500_000;

endpackage

// File: rtl/note_cmd_if.sv
// Valid/ready command channel carrying one note (half-period + duration).
interface note_cmd_if #(
    parameter int PW = 16,
    parameter int DW = 24
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [PW-1:0] cmd_period;
    logic [DW-1:0] cmd_dur;

    modport master (output cmd_valid, output cmd_period, output cmd_dur, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_period, input cmd_dur, output cmd_ready);
endinterface

// File: rtl/note_fifo.sv
// Synchronous FIFO for queued note commands; a push is refused whenever the
// FIFO is full, even if a pop happens in the same cycle.
module note_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/note_player.sv
// Square-wave note player fed from a command FIFO. Optional inter-note
// silence is built when NOTE_PLAYER_GAP_EN is defined.
module note_player
    import note_player_pkg::*;
#(
    parameter int PW    = 16,
    parameter int DW    = 24,
    parameter int DEPTH = 4,
    parameter int GAP   = 1200000
) (
    input  logic      clk,
    input  logic      rst,
    note_cmd_if.slave cmd,
    output logic      ch_out,
    output logic      busy
);
    state_t           state;
    logic [PW-1:0]    period;
    logic [PW-1:0]    hp_cnt;
    logic [DW-1:0]    dur;
    logic [DW-1:0]    dur_cnt;
    logic [PW+DW-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

`ifdef NOTE_PLAYER_GAP_EN
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    logic [GW-1:0] gap_cnt;
`endif

    note_fifo #(.WIDTH(PW + DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd.cmd_valid),
        .pop   (pop),
        .din   ({cmd.cmd_period, cmd.cmd_dur}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd.cmd_ready = !fifo_full;
    assign pop           = (state == ST_LOAD);
    assign busy          = !fifo_empty || (state != ST_IDLE);

    // NOTE: every register here is state, so only non-blocking assignments are used.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            period  <= '0;
            dur     <= '0;
            hp_cnt  <= '0;
            dur_cnt <= '0;
            ch_out  <= 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
            gap_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    ch_out <= 1'b0;
                    if (!fifo_empty) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    period  <= head[PW+DW-1:DW];
                    dur     <= head[DW-1:0];
                    hp_cnt  <= '0;
                    dur_cnt <= '0;
                    ch_out  <= 1'b0;
                    if (head[DW-1:0] != '0) begin
                        state <= ST_PLAY;
                    end else begin
`ifdef NOTE_PLAYER_GAP_EN
                        state   <= ST_GAP;
                        gap_cnt <= '0;
`else
                        state <= ST_IDLE;
`endif
                    end
                end
                ST_PLAY: begin
                    if (dur_cnt == dur - 1'b1) begin
                        // Silence immediately on note end, whatever the wave phase.
                        ch_out <= 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
                        state   <= ST_GAP;
                        gap_cnt <= '0;
`else
                        state <= fifo_empty ? ST_IDLE : ST_LOAD;
`endif
                    end else begin
                        dur_cnt <= dur_cnt + 1'b1;
                        if (period != '0 && hp_cnt == period - 1'b1) begin
                            ch_out <= ~ch_out;
                            hp_cnt <= '0;
                        end else if (period != '0) begin
                            hp_cnt <= hp_cnt + 1'b1;
                        end
                    end
                end
`ifdef NOTE_PLAYER_GAP_EN
                ST_GAP: begin
                    ch_out <= 1'b0;
                    if (gap_cnt == GW'(GAP - 1)) begin
                        state <= fifo_empty ? ST_IDLE : ST_LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state  <= ST_IDLE;
                    ch_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed self-checking bench for note_player; traces ch_out cycle by cycle
// while busy and compares against hand-computed figures and a waveform model.
module tb_note_player;
    localparam int PW      = 16;
    localparam int DW      = 24;
    localparam int GAP_CYC = 5;
`ifdef NOTE_PLAYER_GAP_EN
    localparam int GAP_LEN = GAP_CYC;
`else
    localparam int GAP_LEN = 0;
`endif

    typedef struct {
        int p;
        int d;
    } note_t;

    logic clk = 1'b0;
    logic rst;
    logic ch_out;
    logic busy;

    note_t notes[$];
    bit    trace[$];
    bit    exp_tr[$];
    int    checks = 0;
    int    errors = 0;
    int    push_waits;
    logic  ready_after;

    note_cmd_if #(.PW(PW), .DW(DW)) cmd_bus ();

    note_player #(.PW(PW), .DW(DW), .DEPTH(4), .GAP(GAP_CYC)) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd    (cmd_bus),
        .ch_out (ch_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic push_cmd(input int p, input int d);
        int w = 0;
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_period = PW'(p);
        cmd_bus.cmd_dur    = DW'(d);
        while (!cmd_bus.cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        push_waits += w;
        if (w == 200) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_ready stayed %0b for %0d cycles, required 1", cmd_bus.cmd_ready, w);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic push_all();
        push_waits = 0;
        foreach (notes[i]) push_cmd(notes[i].p, notes[i].d);
        ready_after       = cmd_bus.cmd_ready;
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic capture();
        int n = 0;
        trace = {};
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            checks++;
            errors++;
            $display("FAIL capture_start: busy=%0b after %0d cycles, required 1", busy, n);
            return;
        end
        n = 0;
        while (busy && n < 3000) begin
            trace.push_back(ch_out);
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL capture_end: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Waveform model: one idle cycle, then per note a LOAD cycle, dur cycles of
    // a square wave starting low with half-period p, then the optional gap.
    function automatic void build_expected();
        exp_tr = {};
        exp_tr.push_back(1'b0);
        foreach (notes[i]) begin
            exp_tr.push_back(1'b0);
            for (int k = 0; k < notes[i].d; k++)
                exp_tr.push_back((notes[i].p != 0) && (((k / notes[i].p) % 2) == 1));
`ifdef NOTE_PLAYER_GAP_EN
            for (int g = 0; g < GAP_CYC; g++) exp_tr.push_back(1'b0);
`else
            if (notes[i].d == 0 && i != notes.size() - 1) exp_tr.push_back(1'b0);
`endif
        end
    endfunction

    function automatic int first_mismatch();
        int lim = (trace.size() < exp_tr.size()) ? trace.size() : exp_tr.size();
        for (int i = 0; i < lim; i++)
            if (trace[i] != exp_tr[i]) return i;
        return -1;
    endfunction

    function automatic int count_rises();
        int r = 0;
        for (int i = 0; i < trace.size(); i++)
            if (trace[i] && (i == 0 || !trace[i-1])) r++;
        return r;
    endfunction

    function automatic int first_one();
        for (int i = 0; i < trace.size(); i++)
            if (trace[i]) return i;
        return -1;
    endfunction

    task automatic run_notes();
        fork
            push_all();
            capture();
        join
        build_expected();
    endtask

    task automatic test_reset();
        rst                = 1'b1;
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_period = '0;
        cmd_bus.cmd_dur    = '0;
        @(negedge clk);
        checks++; if (ch_out !== 1'b0) begin errors++; $display("FAIL reset_ch_out: got %0b, expected 0", ch_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        checks++; if (cmd_bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b, expected 1", cmd_bus.cmd_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_tone();
        int mm;
        notes = '{'{4, 40}};
        run_notes();
        mm = first_mismatch();
        checks++; if (trace.size() !== 42 + GAP_LEN) begin errors++; $display("FAIL tone_len: got %0d, expected %0d", trace.size(), 42 + GAP_LEN); end
        checks++; if (mm !== -1) begin errors++; $display("FAIL tone_wave: first difference at cycle %0d, got %0b expected %0b", mm, trace[mm], exp_tr[mm]); end
        checks++; if (count_rises() !== 5) begin errors++; $display("FAIL tone_periods: got %0d, expected 5", count_rises()); end
        checks++; if (first_one() !== 6) begin errors++; $display("FAIL tone_first_high: got %0d, expected 6", first_one()); end
        checks++; if (ch_out !== 1'b0) begin errors++; $display("FAIL tone_idle_out: got %0b, expected 0", ch_out); end
    endtask

    task automatic test_back_to_back();
        int mm;
        notes = '{'{1, 10}, '{2, 12}, '{3, 14}, '{0, 9}, '{2, 11}};
        run_notes();
        mm = first_mismatch();
        checks++; if (push_waits !== 0) begin errors++; $display("FAIL b2b_accept: got %0d stall cycles, expected 0", push_waits); end
        checks++; if (ready_after !== 1'b0) begin errors++; $display("FAIL b2b_full: cmd_ready got %0b, expected 0", ready_after); end
        checks++; if (trace.size() !== 62 + 5 * GAP_LEN) begin errors++; $display("FAIL b2b_len: got %0d, expected %0d", trace.size(), 62 + 5 * GAP_LEN); end
        checks++; if (mm !== -1) begin errors++; $display("FAIL b2b_order: first difference at cycle %0d, got %0b expected %0b", mm, trace[mm], exp_tr[mm]); end
        checks++; if (count_rises() !== 13) begin errors++; $display("FAIL b2b_rises: got %0d, expected 13", count_rises()); end
        checks++; if (cmd_bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %0b, expected 1", cmd_bus.cmd_ready); end
    endtask

    task automatic test_rest_then_tone();
        int mm;
        notes = '{'{0, 20}, '{2, 8}};
        run_notes();
        mm = first_mismatch();
        checks++; if (trace.size() !== 31 + 2 * GAP_LEN) begin errors++; $display("FAIL rest_len: got %0d, expected %0d", trace.size(), 31 + 2 * GAP_LEN); end
        checks++; if (mm !== -1) begin errors++; $display("FAIL rest_wave: first difference at cycle %0d, got %0b expected %0b", mm, trace[mm], exp_tr[mm]); end
        checks++; if (count_rises() !== 2) begin errors++; $display("FAIL rest_periods: got %0d, expected 2", count_rises()); end
        checks++; if (first_one() !== 25 + GAP_LEN) begin errors++; $display("FAIL rest_first_high: got %0d, expected %0d", first_one(), 25 + GAP_LEN); end
    endtask

    task automatic test_zero_dur();
        int mm;
        notes = '{'{3, 0}};
        run_notes();
        mm = first_mismatch();
        checks++; if (trace.size() !== 2 + GAP_LEN) begin errors++; $display("FAIL zero_len: got %0d, expected %0d", trace.size(), 2 + GAP_LEN); end
        checks++; if (mm !== -1) begin errors++; $display("FAIL zero_wave: first difference at cycle %0d, got %0b expected %0b", mm, trace[mm], exp_tr[mm]); end
        checks++; if (count_rises() !== 0) begin errors++; $display("FAIL zero_toggles: got %0d, expected 0", count_rises()); end
    endtask

    task automatic test_reset_mid_note();
        int stray = 0;
        notes = '{'{2, 100}, '{2, 100}, '{3, 50}};
        push_all();
        repeat (10) @(negedge clk);
        checks++; if (ch_out !== 1'b1) begin errors++; $display("FAIL mid_phase: got %0b, expected 1", ch_out); end
        rst                = 1'b1;
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_period = 16'd5;
        cmd_bus.cmd_dur    = 24'd50;
        @(negedge clk);
        rst               = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        checks++; if (ch_out !== 1'b0) begin errors++; $display("FAIL mid_rst_ch_out: got %0b, expected 0", ch_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b, expected 0", busy); end
        checks++; if (cmd_bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0b, expected 1", cmd_bus.cmd_ready); end
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || ch_out !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL mid_rst_quiet: got %0d active cycles, expected 0", stray); end
    endtask

`ifdef NOTE_PLAYER_GAP_EN
    task automatic test_gap();
        int mm;
        int gap_ones = 0;
        notes = '{'{1, 6}, '{1, 6}};
        run_notes();
        mm = first_mismatch();
        for (int i = 8; i < 14 && i < trace.size(); i++) gap_ones += int'(trace[i]);
        checks++; if (trace.size() !== 25) begin errors++; $display("FAIL gap_len: got %0d, expected 25", trace.size()); end
        checks++; if (mm !== -1) begin errors++; $display("FAIL gap_wave: first difference at cycle %0d, got %0b expected %0b", mm, trace[mm], exp_tr[mm]); end
        checks++; if (count_rises() !== 6) begin errors++; $display("FAIL gap_rises: got %0d, expected 6", count_rises()); end
        checks++; if (gap_ones !== 0) begin errors++; $display("FAIL gap_silence: got %0d high cycles, expected 0", gap_ones); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_tone();
        test_back_to_back();
        test_rest_then_tone();
        test_zero_dur();
`ifdef NOTE_PLAYER_GAP_EN
        test_gap();
`endif
        test_reset_mid_note();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 Parameter PW, default 16, width of note half-period field in clock cycles.
REQ-002 Parameter DW, default 24, width of note duration field in clock cycles.
REQ-003 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-004 Parameter GAP, default 1200000, silence cycles between notes (used only with gap feature).
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  upstream command present.
REQ-008 cmd_ready  output  1  FIFO can accept a command this cycle.
REQ-009 cmd_period  input  PW  half-period in cycles; 0 = rest (silence).
REQ-010 cmd_dur  input  DW  note duration in cycles.
REQ-011 ch_out  output  1  square-wave tone output, registered.
REQ-012 busy  output  1  high while FIFO non-empty or FSM not IDLE.

Function
REQ-013 Command accepted on a rising edge with cmd_valid and cmd_ready both high; fields captured into FIFO tail.
REQ-014 cmd_ready SHALL be low exactly when FIFO holds DEPTH entries; a push is refused when full even if a pop occurs the same cycle.
REQ-015 FSM states IDLE, LOAD, PLAY, GAP; no other reachable states.
REQ-016 IDLE -> LOAD when FIFO non-empty; LOAD pops head, latches period/dur, clears counters, goes to PLAY next cycle.
REQ-017 LOAD with latched dur = 0 SHALL skip PLAY and go to GAP (if enabled) else IDLE.
REQ-018 In PLAY, ch_out starts 0; half-period counter increments each cycle and ch_out toggles when counter reaches period-1, counter then returns to 0 (tone frequency clk/(2*period)).
REQ-019 In PLAY with period = 0, ch_out SHALL stay 0 for the whole duration.
REQ-020 PLAY lasts exactly dur cycles; on leaving, ch_out forced 0 the next cycle regardless of phase.
REQ-021 Without gap feature, PLAY end goes to LOAD directly if FIFO non-empty (back-to-back notes, one LOAD cycle of silence), else IDLE.
REQ-022 Counters are unsigned, width PW and DW; no wrap occurs because each is compared against its latched limit.
REQ-023 Commands pushed during PLAY SHALL not disturb the note in progress.
REQ-024 ch_out SHALL be 0 in IDLE, LOAD and GAP.

Reset
REQ-025 rst high SHALL, at the next rising edge, empty the FIFO, set FSM to IDLE, clear all counters, drive ch_out=0, busy=0, cmd_ready=1.
REQ-026 rst asserted mid-note SHALL abort the note; commands pending in FIFO are discarded; a push in the reset cycle is ignored.

Configuration
REQ-027 Macro NOTE_PLAYER_GAP_EN: when defined, after each PLAY (or zero-duration LOAD) the FSM enters GAP for exactly GAP cycles with ch_out=0, then LOAD if FIFO non-empty else IDLE.
REQ-028 When NOTE_PLAYER_GAP_EN is undefined, GAP state and its counter are not built and GAP parameter is ignored.

Structure
REQ-029 Shared package holds FSM state encoding and the note half-period constants (DO_4 .. SI_4) and duration constants used by upstream sequencers.
REQ-030 FIFO is one sub-module, note_fifo (parameters width PW+DW, DEPTH; push/pop/full/empty).

Verification
REQ-031 Push {period=4, dur=40}, gap off -> ch_out 0 for 4 cycles then toggles every 4 cycles, exactly 5 full periods, then 0; busy falls after.
REQ-032 Push 5 commands back-to-back with DEPTH=4 while player busy -> cmd_ready low after 4th accepted entry (first already popped allows 5th); no command lost or duplicated; order preserved.
REQ-033 Push {period=0, dur=20} then {period=2, dur=8} -> 20 cycles silence, one LOAD cycle, then 8-cycle tone with 2 full periods.
REQ-034 Push {period=3, dur=0} -> no toggles on ch_out, FSM returns to IDLE within 2 cycles.
REQ-035 Assert rst for 1 cycle at cycle 10 of a {period=2, dur=100} note with 2 queued -> ch_out=0, busy=0, cmd_ready=1 next cycle; no further tone.
REQ-036 NOTE_PLAYER_GAP_EN defined, GAP=5, two {period=1, dur=6} notes -> 6 toggling cycles, 5 silent cycles, LOAD, 6 toggling cycles.
